// File: rtl/alarm_pkg.sv
// Shared state encoding and widths for the multi-zone alarm controller.
package alarm_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_DISARMED = 3'd0,
    ST_ARMED    = 3'd1,
    ST_ENTRY    = 3'd2,
    ST_ALARM    = 3'd3,
    ST_SILENCED = 3'd4
  } alarm_state_t;

endpackage

// File: rtl/alarm_sync.sv
// Parametrised-width two-flop synchroniser for asynchronous pin inputs.
module alarm_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/multi_zone_alarm.sv
// Multi-zone security controller: arm refusal, entry delay, timed siren, zone memory.
// Optional tamper input/latch enabled by defining ALARM_TAMPER_EN.
module multi_zone_alarm
  import alarm_pkg::*;
#(
  parameter int unsigned NUM_ZONES    = 4,
  parameter int unsigned ENTRY_DLY    = 16,
  parameter int unsigned ALARM_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 arm,
  input  logic                 disarm,
  input  logic [NUM_ZONES-1:0] sensor,
  input  logic [NUM_ZONES-1:0] zone_en,
`ifdef ALARM_TAMPER_EN
  input  logic                 tamper,
  output logic                 tamper_latched,
`endif
  output logic                 alarm,
  output logic [2:0]           state,
  output logic [NUM_ZONES-1:0] zone_latched,
  output logic                 arm_fault,
  output logic                 entry_active
);

  localparam int unsigned CNT_MAX = (ENTRY_DLY > ALARM_CYCLES) ? ENTRY_DLY : ALARM_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DLY - 1);
  localparam logic [CNT_W-1:0] ALARM_LOAD = CNT_W'(ALARM_CYCLES - 1);

  logic [NUM_ZONES-1:0] s_sync;
  logic [NUM_ZONES-1:0] hits;
  logic [NUM_ZONES-1:0] new_hits;
  logic                 hit;
  logic                 arm_rise;

  alarm_state_t         state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_ZONES-1:0] zone_latched_q, zone_latched_d;
  logic                 arm_fault_q, arm_fault_d;
  logic                 arm_prev_q, arm_prev_d;

  alarm_sync #(.WIDTH(NUM_ZONES)) u_sensor_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sensor),
    .q     (s_sync)
  );

`ifdef ALARM_TAMPER_EN
  logic tamper_s;
  logic tamper_latched_q, tamper_latched_d;

  alarm_sync #(.WIDTH(1)) u_tamper_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (tamper),
    .q     (tamper_s)
  );
`endif

  always_comb begin
    hits     = s_sync & zone_en;
    hit      = |hits;
    new_hits = hits & ~zone_latched_q;
    arm_rise = arm & ~arm_prev_q;

    state_d        = state_q;
    cnt_d          = cnt_q;
    zone_latched_d = zone_latched_q;
    arm_fault_d    = 1'b0;
    arm_prev_d     = arm;
`ifdef ALARM_TAMPER_EN
    tamper_latched_d = tamper_latched_q | tamper_s;
`endif

    if (disarm) begin
      state_d        = ST_DISARMED;
      cnt_d          = '0;
      zone_latched_d = '0;
    end
`ifdef ALARM_TAMPER_EN
    else if (tamper_s) begin
      state_d = ST_ALARM;
      cnt_d   = ALARM_LOAD;
    end
`endif
    else begin
      case (state_q)
        ST_DISARMED: begin
          // Refusal only pulses on a fresh arm edge so a held button cannot spam faults.
          if (arm) begin
            if (!hit) begin
              state_d = ST_ARMED;
            end else if (arm_rise) begin
              arm_fault_d = 1'b1;
            end
          end
        end
        ST_ARMED: begin
          if (hit) begin
            state_d        = ST_ENTRY;
            cnt_d          = ENTRY_LOAD;
            zone_latched_d = zone_latched_q | hits;
          end
        end
        ST_ENTRY: begin
          zone_latched_d = zone_latched_q | hits;
          if (cnt_q == '0) begin
            state_d = ST_ALARM;
            cnt_d   = ALARM_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_ALARM: begin
          zone_latched_d = zone_latched_q | hits;
          if (cnt_q == '0) begin
            state_d = ST_SILENCED;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_SILENCED: begin
          if (|new_hits) begin
            state_d        = ST_ALARM;
            cnt_d          = ALARM_LOAD;
            zone_latched_d = zone_latched_q | new_hits;
          end
        end
        default: begin
          state_d        = ST_DISARMED;
          cnt_d          = '0;
          zone_latched_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_DISARMED;
      cnt_q          <= '0;
      zone_latched_q <= '0;
      arm_fault_q    <= 1'b0;
      arm_prev_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      zone_latched_q <= zone_latched_d;
      arm_fault_q    <= arm_fault_d;
      arm_prev_q     <= arm_prev_d;
    end
  end

`ifdef ALARM_TAMPER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tamper_latched_q <= 1'b0;
    end else begin
      tamper_latched_q <= tamper_latched_d;
    end
  end

  assign tamper_latched = tamper_latched_q;
`endif

  assign alarm        = (state_q == ST_ALARM);
  assign entry_active = (state_q == ST_ENTRY);
  assign state        = state_q;
  assign zone_latched = zone_latched_q;
  assign arm_fault    = arm_fault_q;

endmodule
